trigger_ce_sequencer: RTL

TRIGGER_CE_SEQUENCER -- requirements
Module: trigger_ce_sequencer

---
 rtl/trigger_ce_pkg.sv | 21 ++
 rtl/trig_edge_detect.sv | 65 ++++++
 rtl/trigger_ce_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/trigger_ce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trigger_ce_pkg
// Description : Shared types and constants for the trigger-driven clock-enable
//               sequencer (state encoding and state width).
// Revision    : 1.0 - initial release
// ============================================================================
package trigger_ce_pkg;

    // Width of the sequencer state register
    localparam int c_STATE_W = 2;

    // Sequencer states; encoding is fixed so that state can be probed directly
    typedef enum logic [c_STATE_W-1:0] {
        IDLE  = 2'b00,
        DELAY = 2'b01,
        GATED = 2'b10
    } state_t;

endpackage : trigger_ce_pkg
`default_nettype wire

// File: rtl/trig_edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : trig_edge_detect
// Description : Per-channel trigger qualification (rising edge or level),
//               channel masking and lowest-index priority selection.
//               Qualification outputs are combinational from the current
//               trigger sample and the registered history.
// Revision    : 1.0 - initial release
// ============================================================================
module trig_edge_detect
    import trigger_ce_pkg::*;
#(
    parameter int NUM_TRIG  = 4,
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_TRIG-1:0] i_trig,
    input  logic [NUM_TRIG-1:0] i_mask,
    output logic                o_qual_any,
    output logic [NUM_TRIG-1:0] o_qual_onehot
);

    localparam logic [NUM_TRIG-1:0] c_ONE = NUM_TRIG'(1);

    // Raw per-channel hit before masking
    logic [NUM_TRIG-1:0] w_hit;
    // Masked hits
    logic [NUM_TRIG-1:0] w_qual;

    generate
        if (EDGE_MODE) begin : g_edge_mode
            // Previous-cycle trigger sample; updated every cycle regardless of
            // sequencer state so a trigger held through a sequence never re-fires
            logic [NUM_TRIG-1:0] r_trig_prev;

            // Capture trigger history for rising-edge detection
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_trig_prev <= '0;
                end else begin
                    r_trig_prev <= i_trig;
                end
            end

            assign w_hit = i_trig & ~r_trig_prev;
        end else begin : g_level_mode
            assign w_hit = i_trig;
        end
    endgenerate

    // Per-channel masking
    genvar gi;
    generate
        for (gi = 0; gi < NUM_TRIG; gi++) begin : g_chan
            assign w_qual[gi] = w_hit[gi] & i_mask[gi];
        end
    endgenerate

    // Isolate the lowest set bit: x & (-x) keeps only the least significant one
    assign o_qual_onehot = w_qual & (~w_qual + c_ONE);
    assign o_qual_any    = |w_qual;

endmodule : trig_edge_detect
`default_nettype wire

// File: rtl/trigger_ce_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : trigger_ce_sequencer
// Description : On an accepted trigger, waits a programmable delay and then
//               drops a registered clock enable for a programmable number of
//               cycles (or until released when the hold length is zero).
//               Triggers arriving while a sequence runs are flagged as overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_ce_sequencer
    import trigger_ce_pkg::*;
#(
    parameter int NUM_TRIG  = 4,
    parameter int CNT_W     = 16,
    parameter bit EDGE_MODE = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_TRIG-1:0] trig_i,
    input  logic [NUM_TRIG-1:0] trig_mask_i,
    input  logic [CNT_W-1:0]    delay_i,
    input  logic [CNT_W-1:0]    hold_i,
    input  logic                release_i,
    output logic                clock_enable_o,
    output logic                busy_o,
    output logic [NUM_TRIG-1:0] trig_src_o,
    output logic                overrun_o
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_hold;
    logic                r_ce;
    logic                r_busy;
    logic [NUM_TRIG-1:0] r_src;
    logic                r_overrun;

    logic                w_qual_any;
    logic [NUM_TRIG-1:0] w_qual_onehot;

    trig_edge_detect #(
        .NUM_TRIG  (NUM_TRIG),
        .EDGE_MODE (EDGE_MODE)
    ) u_edge (
        .clk           (clk),
        .rst           (rst),
        .i_trig        (trig_i),
        .i_mask        (trig_mask_i),
        .o_qual_any    (w_qual_any),
        .o_qual_onehot (w_qual_onehot)
    );

    // Sequencer FSM: IDLE -> DELAY (count D) -> GATED (count H or wait release)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_hold    <= '0;
            r_ce      <= 1'b1;
            r_busy    <= 1'b0;
            r_src     <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    // release is irrelevant here; a trigger always starts
                    if (w_qual_any) begin
                        r_state <= DELAY;
                        r_busy  <= 1'b1;
                        r_cnt   <= delay_i;
                        r_hold  <= hold_i;
                        r_src   <= w_qual_onehot;
                    end
                end
                DELAY: begin
                    r_overrun <= w_qual_any;
                    if (release_i) begin
                        // Abort takes priority over a simultaneous expiry
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (r_cnt == '0) begin
                        r_state <= GATED;
                        r_ce    <= 1'b0;
                        // H-1 so the enable stays low for exactly H cycles
                        r_cnt   <= (r_hold != '0) ? (r_hold - c_CNT_ONE) : '0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                GATED: begin
                    r_overrun <= w_qual_any;
                    if (release_i || ((r_hold != '0) && (r_cnt == '0))) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_ce    <= 1'b1;
                        r_cnt   <= '0;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_ce    <= 1'b1;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign clock_enable_o = r_ce;
    assign busy_o         = r_busy;
    assign trig_src_o     = r_src;
    assign overrun_o      = r_overrun;

endmodule : trigger_ce_sequencer
`default_nettype wire
